// File: rtl/vmem_blit_pkg.sv
// Shared definitions for the rectangle-fill blitter: register map, FSM encoding,
// screen geometry and the clip helper used when a fill is set up.
package vmem_blit_pkg;

  localparam int SCREEN_W_DEF = 240;
  localparam int SCREEN_H_DEF = 240;
  localparam int VADDR_W      = 16;
  localparam int PIX_W        = 3;

  // Register select is reg_addr[3:2]
  localparam logic [1:0] REG_XY    = 2'd0;
  localparam logic [1:0] REG_WH    = 2'd1;
  localparam logic [1:0] REG_COLOR = 2'd2;
  localparam logic [1:0] REG_CTRL  = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Visible length of a span starting at org: 0 when org is off-screen, else min(len, lim-org)
  function automatic logic [8:0] clip_extent(input logic [7:0] org,
                                             input logic [8:0] len,
                                             input logic [8:0] lim);
    logic [8:0] room;
    room = lim - {1'b0, org};
    if ({1'b0, org} >= lim) return 9'd0;
    return (len < room) ? len : room;
  endfunction

endpackage

// File: rtl/vmem_wr_arb.sv
// Registered two-source vmem write mux. The CPU always wins; the blitter is told
// through blit_ready_o whether its pixel was taken this cycle.
module vmem_wr_arb
  import vmem_blit_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cpu_we_i,
  input  logic [VADDR_W-1:0] cpu_addr_i,
  input  logic [PIX_W-1:0]   cpu_data_i,
  input  logic               blit_req_i,
  input  logic [VADDR_W-1:0] blit_addr_i,
  input  logic [PIX_W-1:0]   blit_data_i,
  output logic               blit_ready_o,
  output logic               we_o,
  output logic [VADDR_W-1:0] addr_o,
  output logic [PIX_W-1:0]   data_o
);

  logic               we_d, we_q;
  logic [VADDR_W-1:0] addr_d, addr_q;
  logic [PIX_W-1:0]   data_d, data_q;

  assign blit_ready_o = ~cpu_we_i;

  // Address/data hold their last value when nothing writes, to avoid needless toggling
  always_comb begin
    we_d   = cpu_we_i | blit_req_i;
    addr_d = addr_q;
    data_d = data_q;
    if (cpu_we_i) begin
      addr_d = cpu_addr_i;
      data_d = cpu_data_i;
    end else if (blit_req_i) begin
      addr_d = blit_addr_i;
      data_d = blit_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign we_o   = we_q;
  assign addr_o = addr_q;
  assign data_o = data_q;

endmodule

// File: rtl/vmem_blit.sv
// Rectangle-fill accelerator: four memory-mapped registers program a clipped
// fill that is walked row-major, one pixel per cycle, behind the CPU's own stores.
module vmem_blit
  import vmem_blit_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               reg_we_i,
  input  logic [3:0]         reg_addr_i,
  input  logic [31:0]        reg_wdata_i,
  output logic [31:0]        reg_rdata_o,
  input  logic               cpu_vwe_i,
  input  logic [VADDR_W-1:0] cpu_vaddr_i,
  input  logic [PIX_W-1:0]   cpu_vdata_i,
  output logic               vmem_we_o,
  output logic [VADDR_W-1:0] vmem_waddr_o,
  output logic [PIX_W-1:0]   vmem_wdata_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [8:0] LIM_W = 9'(SCREEN_W);
  localparam logic [8:0] LIM_H = 9'(SCREEN_H);

  logic [1:0]       state_d, state_q;
  logic [15:0]      xy_d, xy_q;
  logic [8:0]       w_d, w_q, h_d, h_q;
  logic [PIX_W-1:0] color_d, color_q, pix_d, pix_q;
  logic [8:0]       cx_d, cx_q, cy_d, cy_q;
  logic [8:0]       x_last_d, x_last_q, y_last_d, y_last_q;
  logic             sticky_d, sticky_q;
  logic [31:0]      rdata_d, rdata_q;

  logic [1:0] sel;
  logic       busy, start, blit_req, blit_ready;
  logic [7:0] x0, y0;
  logic [8:0] w_eff, h_eff;
  logic       unused_bits;

  assign sel         = reg_addr_i[3:2];
  assign x0          = xy_q[7:0];
  assign y0          = xy_q[15:8];
  assign busy        = (state_q != ST_IDLE);
  assign start       = reg_we_i && (sel == REG_CTRL) && reg_wdata_i[0] && !busy;
  assign w_eff       = clip_extent(x0, w_q, LIM_W);
  assign h_eff       = clip_extent(y0, h_q, LIM_H);
  assign blit_req    = (state_q == ST_RUN);
  assign unused_bits = ^{reg_wdata_i[31:25], reg_addr_i[1:0]};

  always_comb begin
    state_d  = state_q;
    xy_d     = xy_q;
    w_d      = w_q;
    h_d      = h_q;
    color_d  = color_q;
    pix_d    = pix_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    x_last_d = x_last_q;
    y_last_d = y_last_q;
    sticky_d = sticky_q;

    // Configuration is frozen for the whole life of a fill
    if (reg_we_i && !busy) begin
      case (sel)
        REG_XY:    xy_d    = reg_wdata_i[15:0];
        REG_WH:    begin
                     w_d = reg_wdata_i[8:0];
                     h_d = reg_wdata_i[24:16];
                   end
        REG_COLOR: color_d = reg_wdata_i[2:0];
        default:   ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SETUP;
          sticky_d = 1'b0;
        end
      end
      ST_SETUP: begin
        pix_d    = color_q;
        cx_d     = {1'b0, x0};
        cy_d     = {1'b0, y0};
        x_last_d = {1'b0, x0} + w_eff - 9'd1;
        y_last_d = {1'b0, y0} + h_eff - 9'd1;
        state_d  = (w_eff == 9'd0 || h_eff == 9'd0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        // A cycle lost to a CPU store leaves the position untouched
        if (blit_ready) begin
          if (cx_q == x_last_q) begin
            cx_d = {1'b0, x0};
            if (cy_q == y_last_q) state_d = ST_DONE;
            else                  cy_d    = cy_q + 9'd1;
          end else begin
            cx_d = cx_q + 9'd1;
          end
        end
      end
      ST_DONE: begin
        sticky_d = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    case (sel)
      REG_XY:    rdata_d = {16'b0, xy_q};
      REG_WH:    rdata_d = {7'b0, h_q, 7'b0, w_q};
      REG_COLOR: rdata_d = {29'b0, color_q};
      REG_CTRL:  rdata_d = {30'b0, sticky_q, busy};
      default:   rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      xy_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      color_q  <= '0;
      pix_q    <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      x_last_q <= '0;
      y_last_q <= '0;
      sticky_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      xy_q     <= xy_d;
      w_q      <= w_d;
      h_q      <= h_d;
      color_q  <= color_d;
      pix_q    <= pix_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      x_last_q <= x_last_d;
      y_last_q <= y_last_d;
      sticky_q <= sticky_d;
      rdata_q  <= rdata_d;
    end
  end

  vmem_wr_arb u_arb (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cpu_we_i     (cpu_vwe_i),
    .cpu_addr_i   (cpu_vaddr_i),
    .cpu_data_i   (cpu_vdata_i),
    .blit_req_i   (blit_req),
    .blit_addr_i  ({cy_q[7:0], cx_q[7:0]}),
    .blit_data_i  (pix_q),
    .blit_ready_o (blit_ready),
    .we_o         (vmem_we_o),
    .addr_o       (vmem_waddr_o),
    .data_o       (vmem_wdata_o)
  );

  assign reg_rdata_o = rdata_q;
  assign busy_o      = busy;
  assign done_o      = (state_q == ST_DONE);

endmodule

// File: doc/vmem_blit.md
# vmem_blit

Rectangle-fill accelerator on the data bus, directly upstream of the 240x240 3-bit video memory. The CPU programs origin, size and colour through four memory-mapped registers, then starts the fill. The block walks the rectangle and writes one pixel per cycle into the vmem write port. The CPU's own vmem stores are merged into the same port and always take priority over the blitter.

## Interface
Parameters:
- `SCREEN_W`, 240, visible columns; pixels with x ≥ SCREEN_W are clipped.
- `SCREEN_H`, 240, visible rows; pixels with y ≥ SCREEN_H are clipped.

Ports:
- `clk_i` in 1: system clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `reg_we_i` in 1: register write strobe (dbus write decoded to this block).
- `reg_addr_i` in 4: register byte offset; bits [3:2] select the register.
- `reg_wdata_i` in 32: register write data.
- `reg_rdata_o` out 32: register read data, registered.
- `cpu_vwe_i` in 1: CPU vmem write strobe.
- `cpu_vaddr_i` in 16: CPU vmem address {y,x}.
- `cpu_vdata_i` in 3: CPU pixel {R,G,B}.
- `vmem_we_o` out 1: merged vmem write strobe.
- `vmem_waddr_o` out 16: merged vmem address {y[7:0], x[7:0]}.
- `vmem_wdata_o` out 3: merged pixel.
- `busy_o` out 1: high whenever the FSM is not IDLE.
- `done_o` out 1: one-cycle pulse at the end of a fill.

## Operation
Registers:
- `0x0 XY`: [7:0] x0, [15:8] y0.
- `0x4 WH`: [8:0] w, [24:16] h; each is 0..511.
- `0x8 COLOR`: [2:0] colour.
- `0xC CTRL`: write bit0=1 starts a fill. Read returns bit0 busy and bit1 sticky done; sticky done is cleared by start.
- All reads return zero in unused bits.
- Writes to XY, WH or COLOR while busy are ignored. A start while busy is ignored.

FSM (IDLE → SETUP → RUN → DONE → IDLE):
- **IDLE**: a start write moves the FSM to SETUP.
- **SETUP**: computes the clipped extents:
  - w_eff = 0 if x0 ≥ SCREEN_W, else min(w, SCREEN_W−x0).
  - h_eff likewise from y0, h and SCREEN_H.
  - Latches colour.
  - If w_eff==0 or h_eff==0, goes to DONE; otherwise goes to RUN with cx=x0, cy=y0.
- **RUN**: each cycle with `cpu_vwe_i`=0, issues pixel (cx,cy) and advances row-major. When cx reaches x0+w_eff−1, cx wraps to x0 and cy increments. After pixel (x0+w_eff−1, y0+h_eff−1), goes to DONE. A cycle with `cpu_vwe_i`=1 issues the CPU write instead; the blitter holds its position (stall, no loss).
- **DONE**: `done_o`=1 and sticky done is set, then IDLE.

Arithmetic:
- Counters are 9 bits wide; the vmem address uses cx[7:0], cy[7:0].
- Clipping guarantees the address never exceeds 239.

## Timing
- Reset values: `vmem_we_o`=0, `vmem_waddr_o`=0, `vmem_wdata_o`=0, `reg_rdata_o`=0, `busy_o`=0, `done_o`=0. All registers are zero and the state is IDLE.
- Reset mid-fill aborts immediately (async). No further vmem writes occur after deassertion.
- `vmem_*` outputs are registered: a selection in cycle n appears on the port in cycle n+1.
- CPU writes pass through with exactly 1-cycle latency in all states.
- Register reads: `reg_rdata_o` is valid the cycle after `reg_addr_i` is presented.
- Start written in cycle T:
  - SETUP in T+1 (`busy_o`=1).
  - First pixel issued in T+2 and visible on `vmem_we_o` in T+3.
  - Uncontended N=w_eff·h_eff pixels: last visible at T+2+N, `done_o` at T+2+N, `busy_o` low from T+3+N.
  - Each CPU-write cycle during RUN adds one cycle.
  - Zero-area fill: `done_o` at T+2, no vmem writes.
- A start write in the same cycle as DONE is ignored (not IDLE yet).

## Structure
- Shared package `vmem_blit_pkg`:
  - register offsets (XY/WH/COLOR/CTRL);
  - FSM state encoding;
  - SCREEN_W/SCREEN_H defaults;
  - the vmem address width (16) and pixel width (3).
- One sub-module, `vmem_wr_arb`: a registered two-source write mux, CPU priority, with a `blit_ready` output that drives the RUN advance.
- The top level routes the CPU's vmem-decoded store through `cpu_v*_i` instead of straight to vmem.

## Test plan
- **Basic fill**: XY=0x0A05, WH=0x00020003, COLOR=5, start → 6 writes in order: addresses 0x0A05,0x0A06,0x0A07,0x0B05,0x0B06,0x0B07, all data 5; `done_o` exactly 1 pulse; CTRL read = 0x2.
- **Clipping**: XY=0xEEEE (238,238), WH=0x00040004 → writes only 0xEEEE,0xEEEF,0xEFEE,0xEFEF. A second case with XY=0x00F0 (x0=240) → zero writes, `done_o` at T+2.
- **CPU contention**: during RUN, assert `cpu_vwe_i` for 3 cycles with address 0x1234, data 2 → those 3 CPU writes appear next cycle; the blit sequence resumes with no skipped or duplicated pixel; `done_o` is delayed by 3 cycles.
- **Busy protection**: write WH and a second start mid-fill → the fill completes with the original size; register readback shows the old WH.
- **Full screen**: XY=0, WH=0x00F000F0 → 57600 writes; final address 0xEFEF; `busy_o` high for 57602 cycles.
- **Reset mid-fill**: pull `rst_ni` low in RUN → `vmem_we_o` drops within the same cycle; after release, state is IDLE and no writes occur.
